// File: rtl/nn_pkg.sv
// Shared state encodings, width defaults and a width helper for the neuron layer sequencer.
package nn_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MAC  = 3'd2,
    ST_ACT  = 3'd3,
    ST_OUT  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Bit width needed to index v items, never less than 1 so single-item configs still elaborate.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Registered signed multiply-accumulate shared by all neurons of a layer.
// NEURON_SAT_EN: saturating, sticky accumulation instead of two's-complement wrap.
module nn_mac #(
  parameter int DW = 16,
  parameter int AW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;

  assign prod     = a * b;
  assign prod_ext = AW'(prod);

`ifdef NEURON_SAT_EN
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  logic signed [AW:0] sum_wide;
  logic               sat_reg;

  assign sum_wide = {acc[AW-1], acc} + {prod_ext[AW-1], prod_ext};

  // Once clipped the neuron stays at the limit until the next clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc     <= '0;
      sat_reg <= 1'b0;
    end else if (en && !sat_reg) begin
      if (sum_wide[AW] != sum_wide[AW-1]) begin
        acc     <= sum_wide[AW] ? ACC_MIN : ACC_MAX;
        sat_reg <= 1'b1;
      end else begin
        acc <= sum_wide[AW-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end
`endif

endmodule

// File: rtl/neuron_layer_seq.sv
// Fully-connected layer sequencer: one shared MAC and an external sigmoid time-multiplexed over
// all neurons. NEURON_SAT_EN selects saturating accumulation inside nn_mac.
module neuron_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN   = 11,
  parameter int N_NEUR = 4,
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int WA     = clog2_min1(N_IN * N_NEUR),
  parameter int IW     = clog2_min1(N_NEUR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic signed [DW-1:0] x_data,
  output logic [WA-1:0]        w_addr,
  input  logic signed [DW-1:0] w_data,
  output logic [AW-1:0]        sig_x,
  input  logic [AW-1:0]        sig_y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [AW-1:0]        y_data,
  output logic [IW-1:0]        y_idx
);

  localparam int KW = clog2_min1(N_IN);
  localparam int MW = clog2_min1(N_IN + 1);

  state_e                state_reg;
  logic [KW-1:0]         k_reg;
  logic [MW-1:0]         m_reg;
  logic [IW-1:0]         n_reg;
  logic [WA-1:0]         base_reg;
  logic signed [DW-1:0]  xbuf_reg [N_IN];

  logic                  mac_clr;
  logic                  mac_en;
  logic signed [DW-1:0]  mac_a;
  logic signed [AW-1:0]  acc;

  // Input buffer: one register per element, written in order during LOAD.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_xbuf
      always_ff @(posedge clk) begin
        if (rst) begin
          xbuf_reg[gi] <= '0;
        end else if (state_reg == ST_LOAD && x_valid && k_reg == KW'(gi)) begin
          xbuf_reg[gi] <= x_data;
        end
      end
    end
  endgenerate

  // MAC cycle 0 only clears; cycle m pairs buf[m-1] with the weight addressed in cycle m-1.
  assign mac_clr = (state_reg == ST_MAC) && (m_reg == '0);
  assign mac_en  = (state_reg == ST_MAC) && (m_reg != '0);
  assign mac_a   = (m_reg != '0) ? xbuf_reg[KW'(m_reg - MW'(1))] : '0;

  nn_mac #(
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (mac_a),
    .b   (w_data),
    .acc (acc)
  );

  // The accumulator holds still through ACT and OUT, so it drives the sigmoid directly.
  assign sig_x = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      x_ready   <= 1'b0;
      y_valid   <= 1'b0;
      w_addr    <= '0;
      y_data    <= '0;
      y_idx     <= '0;
      k_reg     <= '0;
      m_reg     <= '0;
      n_reg     <= '0;
      base_reg  <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_LOAD;
            busy      <= 1'b1;
            x_ready   <= 1'b1;
            k_reg     <= '0;
          end
        end
        ST_LOAD: begin
          if (x_valid) begin
            if (k_reg == KW'(N_IN - 1)) begin
              state_reg <= ST_MAC;
              x_ready   <= 1'b0;
              k_reg     <= '0;
              m_reg     <= '0;
              n_reg     <= '0;
              base_reg  <= '0;
              w_addr    <= '0;
            end else begin
              k_reg <= k_reg + KW'(1);
            end
          end
        end
        ST_MAC: begin
          if (m_reg == MW'(N_IN)) begin
            state_reg <= ST_ACT;
          end else begin
            m_reg <= m_reg + MW'(1);
          end
          if (int'(m_reg) < N_IN - 1) begin
            w_addr <= w_addr + WA'(1);
          end
        end
        ST_ACT: begin
          state_reg <= ST_OUT;
          y_data    <= sig_y;
          y_idx     <= n_reg;
          y_valid   <= 1'b1;
        end
        ST_OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (n_reg == IW'(N_NEUR - 1)) begin
              state_reg <= ST_DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= ST_MAC;
              n_reg     <= n_reg + IW'(1);
              m_reg     <= '0;
              base_reg  <= base_reg + WA'(N_IN);
              w_addr    <= base_reg + WA'(N_IN);
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          x_ready   <= 1'b0;
          y_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Scoreboard bench for neuron_layer_seq with a registered weight ROM and a stand-in activation.
module tb_neuron_layer_seq;

  localparam int N_IN   = 11;
  localparam int N_NEUR = 4;
  localparam int DW     = 16;
  localparam int AW     = 32;
  localparam int WA     = 6;
  localparam int IW     = 2;
  localparam int LAT    = N_IN + N_NEUR * (N_IN + 3) + 1;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  logic          clk = 1'b0;
  logic          rst, start, busy, done;
  logic          x_valid, x_ready;
  logic [DW-1:0] x_data;
  logic [WA-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [AW-1:0] sig_x, sig_y;
  logic          y_valid, y_ready;
  logic [AW-1:0] y_data;
  logic [IW-1:0] y_idx;

  typedef struct {
    logic [AW-1:0] acc;
    logic [AW-1:0] y;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] xs  [N_IN];
  logic [DW-1:0] rom [N_IN*N_NEUR];

  always #5 clk = ~clk;

  neuron_layer_seq #(.N_IN(N_IN), .N_NEUR(N_NEUR), .DW(DW), .AW(AW), .WA(WA), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .w_addr(w_addr), .w_data(w_data), .sig_x(sig_x), .sig_y(sig_y),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_idx(y_idx)
  );

  // Arbitrary bijective stand-in for sigmoid_32bit; only its determinism matters here.
  function automatic logic [AW-1:0] sig_f(input logic [AW-1:0] v);
    return {v[15:0], v[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  assign sig_y = sig_f(sig_x);

  always @(posedge clk) w_data <= (int'(w_addr) < N_IN*N_NEUR) ? rom[w_addr] : '0;

  function automatic logic [AW-1:0] model_acc(input int n);
    longint s, p;
    bit     sat;
    s = 0;
    sat = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      p = longint'($signed(xs[k])) * longint'($signed(rom[n*N_IN+k]));
`ifdef NEURON_SAT_EN
      if (!sat) begin
        s = s + p;
        if (s > SMAX) begin s = SMAX; sat = 1'b1; end
        else if (s < SMIN) begin s = SMIN; sat = 1'b1; end
      end
`else
      s = s + p;
`endif
    end
    return s[31:0];
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic check_zero(input string tag);
    check_vec({tag, "_busy"},    32'(busy),    0);
    check_vec({tag, "_done"},    32'(done),    0);
    check_vec({tag, "_x_ready"}, 32'(x_ready), 0);
    check_vec({tag, "_y_valid"}, 32'(y_valid), 0);
    check_vec({tag, "_w_addr"},  32'(w_addr),  0);
    check_vec({tag, "_sig_x"},   sig_x,        0);
    check_vec({tag, "_y_data"},  y_data,       0);
    check_vec({tag, "_y_idx"},   32'(y_idx),   0);
  endtask

  task automatic fill_const(input logic [DW-1:0] xv, input logic [DW-1:0] wv);
    for (int i = 0; i < N_IN; i++) xs[i] = xv;
    for (int i = 0; i < N_IN*N_NEUR; i++) rom[i] = wv;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N_IN; i++) xs[i] = DW'($urandom);
    for (int i = 0; i < N_IN*N_NEUR; i++) rom[i] = DW'($urandom);
  endtask

  // Runs one layer; rst_neur >= 0 aborts with reset in that neuron's MAC phase.
  task automatic run_layer(input int gap, input int stall_neur, input int stall_cyc,
                           input int noise, input int rst_neur, input int exp_cycles);
    int            cycles, kk, stall_left;
    logic [WA-1:0] held_addr;
    bit            fin, aborted;
    exp_t          e;
    for (int n = 0; n < N_NEUR; n++) begin
      e.acc = model_acc(n);
      e.y   = sig_f(e.acc);
      e.idx = IW'(n);
      sb.push_back(e);
    end
    cycles = 0; kk = 0; stall_left = stall_cyc; fin = 1'b0; aborted = 1'b0; held_addr = '0;
    start = 1'b1; x_valid = 1'b0; y_ready = 1'b1;
    while (!fin && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
      if (noise == 0) start = 1'b0;
      if (done) begin
        fin = 1'b1;
        x_valid = 1'b0;
        if (exp_cycles > 0) check_vec("latency", 32'(cycles), 32'(exp_cycles));
        check_vec("sb_empty", 32'(sb.size()), 0);
      end else if (rst_neur >= 0 && busy && !y_valid && int'(w_addr) == rst_neur*N_IN + 3) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; x_valid = 1'b0;
        check_zero("mid_rst");
        sb.delete();
        fin = 1'b1; aborted = 1'b1;
      end else begin
        if (x_ready && kk < N_IN) begin
          x_valid = (gap != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
          x_data  = xs[kk];
          if (x_valid) kk++;
        end else begin
          x_valid = 1'b0;
        end
        if (y_valid) begin
          if (sb.size() == 0) begin
            check_vec("sb_underflow", 32'(y_valid), 0);
          end else begin
            check_vec($sformatf("sig_x_n%0d", sb[0].idx), sig_x, sb[0].acc);
            check_vec($sformatf("y_data_n%0d", sb[0].idx), y_data, sb[0].y);
            check_vec("y_idx", 32'(y_idx), 32'(sb[0].idx));
            if (int'(sb[0].idx) == stall_neur && stall_left > 0) begin
              if (stall_left == stall_cyc) held_addr = w_addr;
              else check_vec("w_addr_hold", 32'(w_addr), 32'(held_addr));
              y_ready = 1'b0;
              stall_left--;
            end else begin
              y_ready = 1'b1;
              $display("accept idx=%0d y_data=%h sig_x=%h", y_idx, y_data, sig_x);
              void'(sb.pop_front());
            end
          end
        end else begin
          y_ready = 1'b1;
        end
      end
    end
    if (!fin) check_vec("timeout", 32'(cycles), 0);
    if (fin && !aborted) begin
      @(posedge clk); #1;
      start = 1'b0;
      check_vec("done_pulse", 32'(done), 0);
      check_vec("back_idle", 32'(busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("idle_no_start", 32'(busy), 0);

    fill_const(16'd2, 16'd2);
    run_layer(0, -1, 0, 0, -1, LAT);

    fill_const(16'hFFFD, 16'd5);
    run_layer(0, -1, 0, 0, -1, LAT);

    fill_rand();
    run_layer(0, 1, 10, 0, -1, LAT + 10);

    fill_const(16'h7FFF, 16'h7FFF);
    run_layer(0, -1, 0, 0, -1, LAT);

    fill_rand();
    run_layer(0, -1, 0, 0, 2, -1);
    fill_rand();
    run_layer(0, -1, 0, 0, -1, LAT);

    fill_rand();
    run_layer(1, -1, 0, 1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
